// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: instruction field positions, default reset PC,
// fetch FSM state encodings and small PC arithmetic helpers.
package mips_defs_pkg;

    // Instruction field bit positions (MSB/LSB pairs)
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM16_MSB  = 15;
    localparam int IMM16_LSB  = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    // Default fetch address after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_ERR  = 2'd2
    } fetchState_t;

    // Sequential PC, wraps naturally modulo 2^32
    function automatic logic [31:0] nextPc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Force word alignment of a redirect target
    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Fetch timeout counter: counts consecutive unacknowledged request cycles and
// flags a trip in the cycle the count reaches TIMEOUT.
// The module only exists when IF_FETCH_TIMEOUT_EN is defined, since it is
// instantiated solely in that configuration.
`ifdef IF_FETCH_TIMEOUT_EN
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    input  logic clr,
    output logic trip
);

    // Trip fires while the last allowed unacked cycle is in progress
    localparam logic [7:0] TRIP_AT = 8'(TIMEOUT - 1);

    logic [7:0] cntR;

    // Count unacked requesting cycles; any ack, idle or clear restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntR <= 8'd0;
        end else if (clr || !req || ack) begin
            cntR <= 8'd0;
        end else begin
            cntR <= cntR + 8'd1;
        end
    end

    assign trip = req && !ack && !clr && (cntR == TRIP_AT);

endmodule
`endif

// File: rtl/if_id_stage.sv
// Instruction fetch + IF/ID pipeline register.
// Optional feature macro: IF_FETCH_TIMEOUT_EN (fetch timeout counter, ERR state).
module if_id_stage
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16,
    output logic [25:0] id_target,
    output logic        fetch_err
);

    // Parameter sanity: reject out-of-range timeout at elaboration
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : gBadTimeout
        $error("if_id_stage: TIMEOUT must be within 1..255");
    end

    fetchState_t stateR;
    fetchState_t stateNextS;
    logic [31:0] pcR;
    logic        idValidR;
    logic [31:0] instrR;
    logic [31:0] idPcR;
    logic [31:0] idPc4R;
    logic        canLoadS;
    logic        reqS;
    logic        loadS;
    logic        consumeS;
    logic        redirAccS;
    logic        tripS;

    // Handshake qualifiers; the request drops combinationally on stall/redirect
    always_comb begin
        canLoadS  = !idValidR || !stall;
        reqS      = (stateR == FS_REQ) && canLoadS && !redirect;
        loadS     = reqS && imem_ack;
        consumeS  = idValidR && !stall;
        redirAccS = redirect && (stateR != FS_ERR);
    end

`ifdef IF_FETCH_TIMEOUT_EN
    logic fetchErrR;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) uTimeout (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (reqS),
        .ack   (imem_ack),
        .clr   (redirAccS),
        .trip  (tripS)
    );

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchErrR <= 1'b0;
        end else if (tripS) begin
            fetchErrR <= 1'b1;
        end
    end

    assign fetch_err = fetchErrR;
`else
    assign tripS     = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= FS_IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // FSM next state: IDLE lasts one cycle; ERR is terminal until reset
    always_comb begin
        stateNextS = stateR;
        case (stateR)
            FS_IDLE: stateNextS = FS_REQ;
            FS_REQ: begin
                if (tripS) begin
                    stateNextS = FS_ERR;
                end else begin
                    stateNextS = FS_REQ;
                end
            end
`ifdef IF_FETCH_TIMEOUT_EN
            FS_ERR:  stateNextS = FS_ERR;
`endif
            default: stateNextS = FS_IDLE;
        endcase
    end

    // PC: redirect wins, otherwise advance on each accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcR <= RESET_PC;
        end else if (redirAccS) begin
            pcR <= alignPc(redirect_pc);
        end else if (loadS) begin
            pcR <= nextPc(pcR);
        end
    end

    // Decode valid: flush on redirect, set on load, clear when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idValidR <= 1'b0;
        end else if (redirAccS) begin
            idValidR <= 1'b0;
        end else if (loadS) begin
            idValidR <= 1'b1;
        end else if (consumeS) begin
            idValidR <= 1'b0;
        end
    end

    // Decode payload: only a load changes it, so stall freezes every field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrR <= 32'd0;
            idPcR  <= 32'd0;
            idPc4R <= 32'd0;
        end else if (loadS) begin
            instrR <= imem_data;
            idPcR  <= pcR;
            idPc4R <= nextPc(pcR);
        end
    end

    assign imem_req  = reqS;
    assign imem_addr = pcR;
    assign id_valid  = idValidR;
    assign id_pc     = idPcR;
    assign id_pc4    = idPc4R;
    assign id_opcode = instrR[OPCODE_MSB:OPCODE_LSB];
    assign id_rs     = instrR[RS_MSB:RS_LSB];
    assign id_rt     = instrR[RT_MSB:RT_LSB];
    assign id_rd     = instrR[RD_MSB:RD_LSB];
    assign id_shamt  = instrR[SHAMT_MSB:SHAMT_LSB];
    assign id_funct  = instrR[FUNCT_MSB:FUNCT_LSB];
    assign id_imm16  = instrR[IMM16_MSB:IMM16_LSB];
    assign id_target = instrR[TARGET_MSB:TARGET_LSB];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the fetch stage.
module tb_if_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic [25:0] id_target;
    logic        fetch_err;

    if_id_stage #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_imm16    (id_imm16),
        .id_target   (id_target),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          mStarted;
    bit          mErr;
    bit          mValid;
    logic [31:0] mPc;
    logic [31:0] mWord;
    logic [31:0] mIdPc;
    logic [31:0] mIdPc4;
`ifdef IF_FETCH_TIMEOUT_EN
    int          mUnacked;
`endif
    bit          expReq;
    bit          obsReq;

    task automatic modelReset();
        mStarted = 1'b0;
        mErr     = 1'b0;
        mValid   = 1'b0;
        mPc      = RESET_PC;
        mWord    = 32'd0;
        mIdPc    = 32'd0;
        mIdPc4   = 32'd0;
`ifdef IF_FETCH_TIMEOUT_EN
        mUnacked = 0;
`endif
    endtask

    // One clock: drive inputs, sample request mid-cycle, advance the model.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc,
                         input bit ak, input logic [31:0] dat);
        stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ak; imem_data = dat;
        #1;
        expReq = mStarted && !mErr && (!mValid || !st) && !rd;
        obsReq = imem_req;
        @(posedge clk);
        if (!mErr && rd) begin
            mPc    = rpc & ~32'd3;
            mValid = 1'b0;
        end else if (expReq && ak) begin
            mWord  = dat;
            mIdPc  = mPc;
            mIdPc4 = mPc + 32'd4;
            mValid = 1'b1;
            mPc    = mPc + 32'd4;
        end else if (mValid && !st) begin
            mValid = 1'b0;
        end
`ifdef IF_FETCH_TIMEOUT_EN
        if (expReq && !ak) begin
            mUnacked++;
            if (mUnacked >= TIMEOUT) mErr = 1'b1;
        end else begin
            mUnacked = 0;
        end
`endif
        mStarted = 1'b1;
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_data = 32'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", id_valid); end
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", fetch_err); end
        checks++; if ({id_pc, id_pc4} !== 64'd0) begin failures++; $display("FAIL reset_pcs got=%h/%h want=0/0", id_pc, id_pc4); end
        checks++;
        if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm16, id_target} !== 74'd0) begin
            failures++; $display("FAIL reset_fields got=%h want=0", {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm16, id_target});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h2009_FFFF);
        checks++; if (obsReq !== 1'b0) begin failures++; $display("FAIL idle_req got=%b want=0", obsReq); end
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h2009_FFFF);
        checks++; if (obsReq !== 1'b1) begin failures++; $display("FAIL first_req got=%b want=1", obsReq); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", id_valid); end
        checks++; if (id_opcode !== 6'h08) begin failures++; $display("FAIL first_opcode got=%h want=08", id_opcode); end
        checks++; if (id_rt !== 5'd9) begin failures++; $display("FAIL first_rt got=%0d want=9", id_rt); end
        checks++; if (id_imm16 !== 16'hFFFF) begin failures++; $display("FAIL first_imm got=%h want=ffff", id_imm16); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL first_pc got=%h want=0", id_pc); end
        checks++; if (id_pc4 !== 32'd4) begin failures++; $display("FAIL first_pc4 got=%h want=4", id_pc4); end
        checks++; if (imem_addr !== 32'd4) begin failures++; $display("FAIL first_addr got=%h want=4", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            cycle(1'b0, 1'b0, 32'd0, 1'b1, w);
            checks++; if (obsReq !== 1'b1) begin failures++; $display("FAIL stream_req[%0d] got=%b want=1", i, obsReq); end
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b want=1", i, id_valid); end
            checks++; if (id_pc !== 32'd4 + 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, id_pc, 32'd4 + 32'(4 * i)); end
            checks++;
            if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct} !== w) begin
                failures++; $display("FAIL stream_word[%0d] got=%h want=%h", i, {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, w);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] wordBefore;
        logic [31:0] pcBefore;
        logic [31:0] w;
        wordBefore = mWord;
        pcBefore   = mIdPc;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'd0, 1'b1, $urandom);
            checks++; if (obsReq !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%b want=0", i, obsReq); end
            checks++; if (id_valid !== 1'b1 || id_pc !== pcBefore || id_pc4 !== pcBefore + 32'd4) begin
                failures++; $display("FAIL stall_hold_pc[%0d] got=%b/%h/%h want=1/%h/%h", i, id_valid, id_pc, id_pc4, pcBefore, pcBefore + 32'd4);
            end
            checks++; if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct} !== wordBefore || id_target !== wordBefore[25:0]) begin
                failures++; $display("FAIL stall_hold_word[%0d] got=%h want=%h", i, {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, wordBefore);
            end
        end
        w = $urandom;
        cycle(1'b0, 1'b0, 32'd0, 1'b1, w);
        checks++; if (obsReq !== 1'b1) begin failures++; $display("FAIL release_req got=%b want=1", obsReq); end
        checks++; if (id_pc !== pcBefore + 32'd4) begin failures++; $display("FAIL release_pc got=%h want=%h", id_pc, pcBefore + 32'd4); end
        checks++; if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct} !== w) begin
            failures++; $display("FAIL release_word got=%h want=%h", {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, w);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] wordBefore;
        wordBefore = mWord;
        cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1, ~wordBefore);
        checks++; if (obsReq !== 1'b0) begin failures++; $display("FAIL redir_req got=%b want=0", obsReq); end
        checks++; if (imem_addr !== 32'h0000_0100) begin failures++; $display("FAIL redir_addr got=%h want=00000100", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b want=0", id_valid); end
        checks++; if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct} !== wordBefore) begin
            failures++; $display("FAIL redir_discard got=%h want=%h", {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, wordBefore);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h1234_5678);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0000_0100) begin
            failures++; $display("FAIL redir_reload got=%b/%h want=1/00000100", id_valid, id_pc);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr1 got=%h want=fffffffc", imem_addr); end
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        checks++; if (id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h want=fffffffc", id_pc); end
        checks++; if (id_pc4 !== 32'd0) begin failures++; $display("FAIL wrap_pc4 got=%h want=0", id_pc4); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL wrap_addr2 got=%h want=0", imem_addr); end
    endtask

    task automatic test_random();
        bit          st;
        bit          rd;
        bit          ak;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 15) == 0);
            ak = ($urandom_range(0, 3) != 0);
            cycle(st, rd, $urandom, ak, $urandom);
            checks++; if (obsReq !== expReq) begin failures++; $display("FAIL rand_req[%0d] got=%b want=%b", i, obsReq, expReq); end
            checks++; if (imem_addr !== mPc) begin failures++; $display("FAIL rand_addr[%0d] got=%h want=%h", i, imem_addr, mPc); end
            checks++; if (id_valid !== mValid) begin failures++; $display("FAIL rand_valid[%0d] got=%b want=%b", i, id_valid, mValid); end
            checks++; if (id_pc !== mIdPc || id_pc4 !== mIdPc4) begin
                failures++; $display("FAIL rand_pcs[%0d] got=%h/%h want=%h/%h", i, id_pc, id_pc4, mIdPc, mIdPc4);
            end
            checks++; if ({id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct} !== mWord) begin
                failures++; $display("FAIL rand_word[%0d] got=%h want=%h", i, {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, mWord);
            end
            checks++; if (id_imm16 !== mWord[15:0] || id_target !== mWord[25:0]) begin
                failures++; $display("FAIL rand_imm_tgt[%0d] got=%h/%h want=%h/%h", i, id_imm16, id_target, mWord[15:0], mWord[25:0]);
            end
            checks++; if (fetch_err !== mErr) begin failures++; $display("FAIL rand_err[%0d] got=%b want=%b", i, fetch_err, mErr); end
        end
    endtask

    task automatic test_timeout();
        applyReset();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef IF_FETCH_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            checks++; if (obsReq !== 1'b1) begin failures++; $display("FAIL to_req[%0d] got=%b want=1", i, obsReq); end
            checks++; if (fetch_err !== (i == TIMEOUT - 1)) begin
                failures++; $display("FAIL to_err[%0d] got=%b want=%b", i, fetch_err, (i == TIMEOUT - 1));
            end
        end
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'd0);
        checks++; if (obsReq !== 1'b0) begin failures++; $display("FAIL err_redir_req got=%b want=0", obsReq); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL err_redir_addr got=%h want=%h", imem_addr, RESET_PC); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
            checks++; if (obsReq !== 1'b0 || fetch_err !== 1'b1) begin
                failures++; $display("FAIL err_sticky[%0d] got=%b/%b want=0/1", i, obsReq, fetch_err);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL err_reset got=%b want=0", fetch_err); end
        rst_n = 1'b1;
`else
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            checks++; if (obsReq !== 1'b1 || fetch_err !== 1'b0) begin
                failures++; $display("FAIL noto_wait[%0d] got=%b/%b want=1/0", i, obsReq, fetch_err);
            end
        end
`endif
    endtask

    // Bound the whole run
    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
